// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG conditioner.
// Byte width, default parameter values and the debias pair-state encoding.
package trng_pkg;

    localparam int BYTE_W = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_RCT_LIMIT = 32;

    typedef enum logic {
        PAIR_EMPTY,
        PAIR_HELD
    } pair_e;

endpackage

// File: rtl/trng_sync.sv
// Parameterised-depth single-bit synchronizer with synchronous reset.
// Output is the last flop of the chain.
module trng_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/trng_conditioner.sv
// Raw entropy conditioner: sync, edge-detect, von Neumann debias,
// byte assembly with single-entry output holding and health checks.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int RCT_LIMIT = DEF_RCT_LIMIT,
    parameter int DEBIAS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              raw_bit,
    input  logic              raw_strobe,
    input  logic              clear,
    output logic [BYTE_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              overflow,
    output logic              health_fail
);

    localparam int RW = $clog2(RCT_LIMIT + 1);
    localparam logic [RW-1:0] LIM = RW'(RCT_LIMIT);

    logic bit_s;
    logic strobe_s;
    logic strobe_d;
    logic evt;

    trng_sync #(.STAGES(SYNC_STAGES)) u_sync_bit (
        .clk (clk),
        .rst (rst),
        .d   (raw_bit),
        .q   (bit_s)
    );

    trng_sync #(.STAGES(SYNC_STAGES)) u_sync_strobe (
        .clk (clk),
        .rst (rst),
        .d   (raw_strobe),
        .q   (strobe_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_d <= 1'b0;
        end else begin
            strobe_d <= strobe_s;
        end
    end

    assign evt = en && strobe_s && !strobe_d;

    pair_e pair_q;
    pair_e pair_d;
    logic  held_q;
    logic  held_d;
    logic  emit;
    logic  emit_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q <= PAIR_EMPTY;
            held_q <= 1'b0;
        end else begin
            pair_q <= pair_d;
            held_q <= held_d;
        end
    end

    // Debias emits the first sample of a differing pair.
    always_comb begin
        pair_d   = pair_q;
        held_d   = held_q;
        emit     = 1'b0;
        emit_bit = bit_s;
        if (!en) begin
            pair_d = PAIR_EMPTY;
        end else if (evt) begin
            if (DEBIAS == 0) begin
                emit = 1'b1;
            end else begin
                unique case (pair_q)
                    PAIR_EMPTY: begin
                        pair_d = PAIR_HELD;
                        held_d = bit_s;
                    end
                    PAIR_HELD: begin
                        pair_d   = PAIR_EMPTY;
                        emit     = (held_q != bit_s);
                        emit_bit = held_q;
                    end
                endcase
            end
        end
    end

    logic [RW-1:0] rct_q;
    logic          last_q;
    logic          rep;
    logic          hf_set;

    assign rep    = (rct_q != '0) && (bit_s == last_q);
    assign hf_set = evt && rep && (rct_q >= LIM - RW'(1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            rct_q  <= '0;
            last_q <= 1'b0;
        end else if (evt) begin
            last_q <= bit_s;
            if (!rep) begin
                rct_q <= RW'(1);
            end else if (rct_q != LIM) begin
                rct_q <= rct_q + RW'(1);
            end
        end
    end

    // Only 7 bits are stored; the 8th arrives directly as the new MSB.
    logic [BYTE_W-2:0] shreg;
    logic [2:0]        cnt;
    logic [BYTE_W-1:0] byte_new;
    logic              done;

    assign byte_new = {emit_bit, shreg};
    assign done     = emit && (cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (emit) begin
            shreg <= byte_new[BYTE_W-1:1];
            cnt   <= cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= '0;
            valid       <= 1'b0;
            overflow    <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            if (done && (!valid || ready)) begin
                data  <= byte_new;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            overflow    <= (done && valid && !ready) || (overflow && !clear);
            health_fail <= hf_set || (health_fail && !clear);
        end
    end

endmodule
